mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one byte-wide synchronous RAM port between the instruction-fetch requester (IF) and the load/store stage requester (MEM).
- Arbitrates between the two. Serialises each 32-bit word access into byte cycles. Returns read data and busy/done handshakes in the form the MEM stage already consumes.
- Sits between the pipeline (IF stage, MEM stage) and the external RAM.

Parameters:
ADDR_W, 17, RAM byte-address width; upper request-address bits are ignored.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
if_re  input  1  IF word-read request
if_addr  input  32  IF byte address
if_busy  output  1  IF must stall
if_done  output  1  one-cycle pulse, if_data valid
if_data  output  32  fetched word
mem_re  input  1  MEM word-read request
mem_we  input  1  MEM write request
mem_sel  input  4  MEM byte-write enables, bit k = byte k
mem_addr  input  32  MEM byte address
mem_wdata  input  32  MEM write data, byte lanes pre-positioned
mem_busy  output  1  MEM must stall / not issue
mem_done  output  1  one-cycle pulse, mem_rdata valid
mem_rdata  output  32  loaded word
ram_en  output  1  RAM access strobe
ram_we  output  1  RAM byte write
ram_addr  output  ADDR_W  RAM byte address
ram_wdata  output  8  RAM write byte
ram_rdata  input  8  RAM read byte; valid the cycle after its address is driven with ram_en=1, ram_we=0

Behaviour:
- Reset (rst=0 at an edge):
  - State returns to IDLE and cnt=0, abandoning any transaction in flight.
  - All outputs are 0 from the following cycle, including if_data and mem_rdata.
  - ram_we is never asserted in the cycle after reset.
- States: IDLE, READ, WRITE, DONE. Registers: owner (IF/MEM), cnt[2:0], base[ADDR_W-1:0], wbuf[31:0], sbuf[3:0], rbuf[31:0].
- IDLE: requests are sampled only here.
  - mem_we=1: owner=MEM, go to WRITE. Latch wbuf=mem_wdata and sbuf=mem_sel.
  - Else mem_re=1: owner=MEM, go to READ.
  - Else if_re=1: owner=IF, go to READ.
  - MEM has fixed priority over IF. mem_we together with mem_re is treated as a write.
  - base = {addr[ADDR_W-1:2], 2'b00}; word-aligned, the low two address bits are ignored.
- READ, cnt = 0..4:
  - For cnt<4: ram_en=1, ram_we=0, ram_addr=base+cnt.
  - For cnt≥1: capture ram_rdata into rbuf[8(cnt-1)+7 : 8(cnt-1)] (little-endian).
  - At cnt=4 go to DONE.
- WRITE, cnt = 0..3:
  - ram_en=1, ram_addr=base+cnt, ram_wdata=wbuf[8cnt+7:8cnt], ram_we=sbuf[cnt].
  - Always 4 cycles, even when sbuf=0000. At cnt=3 go to DONE.
- DONE (exactly one cycle):
  - Owner's done=1. For an owner read, the owner's data output is loaded from rbuf.
  - Data outputs hold until the next completion for the same owner.
  - After DONE go to IDLE; there is always one IDLE cycle between transactions.
- Busy rule: X_busy = (state≠IDLE) and not (state=DONE and owner=X).
  - The non-owner sees busy through DONE.
  - Busy is 0 in IDLE. Requests must be held by the requester until accepted; write data and enables are latched, so mem_we may drop after acceptance.
- Latency, counted from the accepting IDLE edge (cycle 0):
  - Read: done in cycle 6, busy in cycles 1–5.
  - Write: done in cycle 5, busy in cycles 1–4.
- Outside READ/WRITE: ram_en=0, ram_we=0, ram_wdata=0; ram_addr holds its last value.
- Address increment base+cnt stays inside the word, so there is no carry out of bits [1:0].
- done outputs are never asserted simultaneously. A request arriving during DONE or a non-IDLE state is ignored until IDLE.

Test Plan:
- Reset then idle: rst=0 two cycles, then rst=1 with no requests → all outputs 0, busy=0.
- IF read: RAM[0x100..0x103]=11,22,33,44; if_re, if_addr=0x102 → ram_addr 0x100..0x103 in cycles 1–4; if_done=1 in cycle 6 with if_data=0x44332211; if_busy=1 in cycles 1–5 only.
- MEM byte write: mem_we, mem_sel=0100, mem_addr=0x201, mem_wdata=0xAABBCCDD → ram_we=1 only in cycle 3 (ram_addr=0x202, ram_wdata=0xBB); mem_done in cycle 5; other RAM bytes unchanged.
- Contention: if_re and mem_re raised together → MEM served first (mem_done cycle 6); if_busy=1 through cycle 6; IF accepted in the IDLE cycle 7 → if_done cycle 13.
- Reset mid-write: rst=0 during WRITE cnt=1 → next cycle state IDLE, ram_we=0, busy=0; later bytes never written.
- Back-to-back loads: mem_re held with new address at each IDLE → mem_done every 7 cycles; mem_rdata stable between pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM port between the
// instruction-fetch requester (IF) and the load/store requester (MEM).
// Each 32-bit word access is serialised into four byte cycles; MEM has
// fixed priority over IF and requests are only sampled while idle.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   if_re/if_addr        IF word-read request and byte address
//   if_busy/if_done      IF stall, one-cycle completion pulse
//   if_data              fetched word, held until the next IF completion
//   mem_re/mem_we        MEM read / write request (write wins if both)
//   mem_sel/mem_addr     MEM byte-write enables and byte address
//   mem_wdata            MEM write data, byte lanes pre-positioned
//   mem_busy/mem_done    MEM stall, one-cycle completion pulse
//   mem_rdata            loaded word, held until the next MEM completion
//   ram_en/ram_we        RAM access strobe and byte write enable
//   ram_addr/ram_wdata   RAM byte address and write byte
//   ram_rdata            RAM read byte, valid the cycle after its address
module mem_arbiter #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_re,
  input  logic [31:0]       if_addr,
  output logic              if_busy,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-3:0] base_q, base_d;   // word address; byte lane comes from cnt
  logic [3:0][7:0]   wbuf_q, wbuf_d;
  logic [3:0][7:0]   rbuf_q, rbuf_d;
  logic [3:0]        sbuf_q, sbuf_d;
  logic [31:0]       if_data_d, mem_rdata_d;
  logic [ADDR_W-1:0] addr_hold_q;

  // Upper address bits beyond the RAM and the byte offset are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], if_addr[1:0],
                              mem_addr[31:ADDR_W], mem_addr[1:0]};

  assign if_done  = (state_q == DONE) && (owner_q == OWN_IF);
  assign mem_done = (state_q == DONE) && (owner_q == OWN_MEM);
  assign if_busy  = (state_q != IDLE) && !if_done;
  assign mem_busy = (state_q != IDLE) && !mem_done;

  // The RAM address is only driven during byte cycles; otherwise it holds.
  assign ram_addr = ram_en ? {base_q, cnt_q[1:0]} : addr_hold_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    wbuf_d      = wbuf_q;
    sbuf_d      = sbuf_q;
    rbuf_d      = rbuf_q;
    if_data_d   = if_data;
    mem_rdata_d = mem_rdata;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_we) begin
          owner_d = OWN_MEM;
          state_d = WRITE;
          base_d  = mem_addr[ADDR_W-1:2];
          wbuf_d  = mem_wdata;
          sbuf_d  = mem_sel;
        end else if (mem_re) begin
          owner_d = OWN_MEM;
          state_d = READ;
          base_d  = mem_addr[ADDR_W-1:2];
        end else if (if_re) begin
          owner_d = OWN_IF;
          state_d = READ;
          base_d  = if_addr[ADDR_W-1:2];
        end
      end
      READ: begin
        if (cnt_q != 3'd4) ram_en = 1'b1;
        // Byte for lane cnt-1 arrives one cycle after its address.
        if (cnt_q != 3'd0) rbuf_d[cnt_q[1:0] - 2'd1] = ram_rdata;
        if (cnt_q == 3'd4) begin
          state_d = DONE;
          // Loaded on entry to DONE so the word is visible with the done pulse.
          if (owner_q == OWN_IF) if_data_d   = rbuf_d;
          else                   mem_rdata_d = rbuf_d;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WRITE: begin
        ram_en    = 1'b1;
        ram_we    = sbuf_q[cnt_q[1:0]];
        ram_wdata = wbuf_q[cnt_q[1:0]];
        if (cnt_q == 3'd3) state_d = DONE;
        else               cnt_d   = cnt_q + 3'd1;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      base_q      <= '0;
      wbuf_q      <= '0;
      sbuf_q      <= '0;
      rbuf_q      <= '0;
      if_data     <= '0;
      mem_rdata   <= '0;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      wbuf_q      <= wbuf_d;
      sbuf_q      <= sbuf_d;
      rbuf_q      <= rbuf_d;
      if_data     <= if_data_d;
      mem_rdata   <= mem_rdata_d;
      addr_hold_q <= ram_addr;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_re, if_busy, if_done;
  logic [31:0] if_addr, if_data;
  logic        mem_re, mem_we, mem_busy, mem_done;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        ram_en, ram_we;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(17)) dut (
    .clk(clk), .rst(rst),
    .if_re(if_re), .if_addr(if_addr), .if_busy(if_busy), .if_done(if_done), .if_data(if_data),
    .mem_re(mem_re), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Synchronous byte RAM (4 KiB window is enough for the addresses used).
  logic [7:0]  ram [0:4095];
  logic        clr, pre_we;
  logic [11:0] pre_addr;
  logic [7:0]  pre_data;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    end else if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr[11:0]] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr[11:0]];
    end
  end

  // Reference model: byte memory plus the last word each requester received.
  logic [7:0]  mm [0:4095];
  logic [31:0] last_if, last_mem;
  int          n_vec, n_err;

  typedef struct {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [10];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    return {mm[b + 12'd3], mm[b + 12'd2], mm[b + 12'd1], mm[b]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d; mm[a] = d;
    tick();
    pre_we = 1'b0;
  endtask

  // One transaction from an IDLE cycle: checks latency, busy/done, RAM bus,
  // data outputs, and the IDLE cycle that follows.
  task automatic do_txn(input logic is_if, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel,
                        input logic [31:0] exp_data);
    int exp_lat, done_cyc;
    bit bus_ok, busy_ok;
    logic [16:0] base;
    logic own_busy, oth_busy, own_done, oth_done, exp_en, exp_we;
    base    = {addr[16:2], 2'b00};
    exp_lat = (!is_if && we) ? 5 : 6;
    if (is_if) begin
      if_re = 1'b1; if_addr = addr;
    end else begin
      mem_we = we; mem_re = we ? 1'($urandom) : 1'b1;
      mem_addr = addr; mem_wdata = wdata; mem_sel = sel;
    end
    tick();
    if_re = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    mem_wdata = $urandom; mem_sel = 4'($urandom);
    done_cyc = 0; bus_ok = 1'b1; busy_ok = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      own_busy = is_if ? if_busy : mem_busy;
      oth_busy = is_if ? mem_busy : if_busy;
      own_done = is_if ? if_done : mem_done;
      oth_done = is_if ? mem_done : if_done;
      if (own_busy !== (c < exp_lat)) busy_ok = 1'b0;
      if (oth_busy !== 1'b1 || oth_done !== 1'b0) busy_ok = 1'b0;
      exp_en = (c <= 4);
      exp_we = exp_en && !is_if && we && sel[c-1];
      if (ram_en !== exp_en || ram_we !== exp_we) bus_ok = 1'b0;
      if (exp_en && ram_addr !== base + 17'(c - 1)) bus_ok = 1'b0;
      if (exp_we && ram_wdata !== wdata[8*(c-1) +: 8]) bus_ok = 1'b0;
      if (c == exp_lat && ram_wdata !== 8'h00) bus_ok = 1'b0;
      if (own_done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    chk("latency", done_cyc, exp_lat);
    chk("busy_done", {31'b0, busy_ok}, 32'd1);
    chk("ram_bus", {31'b0, bus_ok}, 32'd1);
    if (is_if) last_if = exp_data;
    else if (!we) last_mem = exp_data;
    chk("if_data", if_data, last_if);
    chk("mem_rdata", mem_rdata, last_mem);
    if (!is_if && we)
      for (int k = 0; k < 4; k++)
        if (sel[k]) mm[base[11:0] + 12'(k)] = wdata[8*k +: 8];
    tick();
    chk("idle_ctl", {26'b0, if_busy, if_done, mem_busy, mem_done, ram_en, ram_we}, 32'd0);
    chk("addr_hold", {15'b0, ram_addr}, {15'b0, base + 17'd3});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dn [3];
    int mem_dc, if_dc, idx;
    bit ok;
    logic [31:0] b2b [3];
    logic is_if, we;
    logic [31:0] a;

    n_vec = 0; n_err = 0; last_if = '0; last_mem = '0;
    for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
    rst = 1'b0; if_re = 1'b0; if_addr = '0; mem_re = 1'b0; mem_we = 1'b0;
    mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    tick();
    clr = 1'b0;
    poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    poke(12'h104, 8'hA1); poke(12'h105, 8'hA2); poke(12'h106, 8'hA3); poke(12'h107, 8'hA4);
    poke(12'h108, 8'h55); poke(12'h109, 8'h66); poke(12'h10A, 8'h77); poke(12'h10B, 8'h88);

    // Reset then idle.
    rst = 1'b1;
    tick();
    chk("rst_ctl", {26'b0, if_busy, if_done, mem_busy, mem_done, ram_en, ram_we}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_ram_addr", {15'b0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", {24'b0, ram_wdata}, 32'd0);

    // Directed vectors.
    tbl[0] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,         4'b0000, 32'h4433_2211};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_0201, 32'hAABB_CCDD, 4'b0100, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,         4'b0000, 32'h00BB_0000};
    tbl[3] = '{1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0107, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    tbl[5] = '{1'b0, 1'b1, 32'h0000_0108, 32'hFFFF_FFFF, 4'b0000, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 32'h0000_010B, 32'h0,         4'b0000, 32'h8877_6655};
    tbl[7] = '{1'b0, 1'b1, 32'h0000_010C, 32'h1234_5678, 4'b1001, 32'h0};
    tbl[8] = '{1'b1, 1'b0, 32'h0000_010E, 32'h0,         4'b0000, 32'h1200_0078};
    tbl[9] = '{1'b1, 1'b0, 32'h0002_0102, 32'h0,         4'b0000, 32'h4433_2211};
    for (int i = 0; i < 10; i++)
      do_txn(tbl[i].is_if, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sel, tbl[i].exp);

    // Contention: both raise together, MEM first, IF held until accepted.
    if_re = 1'b1; if_addr = 32'h100; mem_re = 1'b1; mem_addr = 32'h104;
    mem_dc = 0; if_dc = 0; ok = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) mem_re = 1'b0;
      if (c == 8) if_re = 1'b0;
      if (if_busy !== ((c <= 6) || (c >= 8 && c <= 12))) ok = 1'b0;
      if (mem_busy !== ((c <= 5) || (c >= 8 && c <= 13))) ok = 1'b0;
      if (mem_done === 1'b1 && if_done === 1'b1) ok = 1'b0;
      if (mem_done === 1'b1 && mem_dc == 0) begin
        mem_dc = c;
        chk("cont_mem_rdata", mem_rdata, model_word(32'h104));
      end
      if (if_done === 1'b1 && if_dc == 0) begin
        if_dc = c;
        chk("cont_if_data", if_data, model_word(32'h100));
      end
    end
    chk("cont_mem_done_cyc", mem_dc, 6);
    chk("cont_if_done_cyc", if_dc, 13);
    chk("cont_busy", {31'b0, ok}, 32'd1);
    last_mem = model_word(32'h104); last_if = model_word(32'h100);

    // Back-to-back loads with mem_re held and the address changed at each IDLE.
    b2b[0] = 32'h100; b2b[1] = 32'h104; b2b[2] = 32'h108;
    dn[0] = 0; dn[1] = 0; dn[2] = 0; idx = 0; ok = 1'b1;
    mem_re = 1'b1; mem_addr = b2b[0];
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (mem_done === 1'b1 && idx < 3) begin
        dn[idx] = c;
        chk("b2b_rdata", mem_rdata, model_word(b2b[idx]));
        last_mem = model_word(b2b[idx]);
        idx++;
        if (idx < 3) mem_addr = b2b[idx];
        else mem_re = 1'b0;
      end else if (mem_rdata !== last_mem) begin
        ok = 1'b0;
      end
    end
    mem_re = 1'b0;
    chk("b2b_done0", dn[0], 6);
    chk("b2b_done1", dn[1], 13);
    chk("b2b_done2", dn[2], 20);
    chk("b2b_hold", {31'b0, ok}, 32'd1);

    // Reset during WRITE cnt=1: bytes 0 and 1 land, 2 and 3 never do.
    mem_we = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h0102_0304; mem_sel = 4'b1111;
    tick();
    mem_we = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("mrst_ctl", {26'b0, if_busy, if_done, mem_busy, mem_done, ram_en, ram_we}, 32'd0);
    chk("mrst_data", if_data | mem_rdata, 32'd0);
    chk("mrst_addr", {15'b0, ram_addr}, 32'd0);
    rst = 1'b1;
    last_if = '0; last_mem = '0;
    mm[12'h300] = 8'h04; mm[12'h301] = 8'h03;
    tick();
    chk("mrst_idle", {30'b0, if_busy, mem_busy}, 32'd0);
    do_txn(1'b0, 1'b0, 32'h300, 32'h0, 4'b0000, model_word(32'h300));

    // Randomized transactions against the byte-memory model.
    for (int i = 0; i < 40; i++) begin
      is_if = 1'($urandom);
      we    = !is_if && 1'($urandom);
      a     = (32'h400 + 32'($urandom_range(0, 255))) | ($urandom & 32'hFFFE_0000);
      do_txn(is_if, we, a, $urandom, 4'($urandom), model_word(a));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
